// File: rtl/frame_swap_ctrl.sv
// frame_swap_ctrl: double-buffer controller between the host pixel writer,
// the top/bottom scanline RAM banks and led_output. The host always writes
// the back frame while led_output scans the front one. Frames swap only at
// a scan boundary, so a partially written frame is never displayed.
module frame_swap_ctrl #(
    parameter int MATRIX_HEIGHT = 32,
    parameter int MATRIX_WIDTH  = 64,
    localparam int BANK_SIZE = MATRIX_HEIGHT * MATRIX_WIDTH / 2,
    localparam int LA        = $clog2(BANK_SIZE),
    localparam int AW        = LA + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic          pix_valid,
    output logic          pix_ready,
    input  logic [15:0]   pix_data,
    input  logic          pix_last,
    output logic          bank0_wen,
    output logic          bank1_wen,
    output logic [AW-1:0] w_addr,
    output logic [15:0]   w_data,
    input  logic [LA-1:0] r_addr,
    output logic [AW-1:0] bank_raddr,
    output logic          go,
    input  logic          scan_done,
    output logic          frame_err
);

    // The pixel counter spans both halves of the panel, i.e. one bit wider
    // than a bank-local address.
    localparam int TOTAL = MATRIX_HEIGHT * MATRIX_WIDTH;
    localparam int PW    = LA + 1;
    localparam logic [PW-1:0] P_LAST = PW'(TOTAL - 1);
    localparam logic [PW-1:0] P_BANK = PW'(BANK_SIZE);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FILL    = 3'd1,
        FLUSH   = 3'd2,
        START   = 3'd3,
        RUN     = 3'd4,
        PENDING = 3'd5
    } state_t;

    state_t          state_reg, state_next;
    logic [PW-1:0]   p_reg;
    logic            rd_frame_reg, wr_frame_reg;
    logic            bank0_wen_reg, bank1_wen_reg, frame_err_reg;
    logic [AW-1:0]   w_addr_reg;
    logic [15:0]     w_data_reg;

    logic            accept, at_end, frame_bad, frame_good, in_bank1, swap;
    logic [LA-1:0]   local_addr;

    // Raster position decoding: the first H/2 rows live in bank0, the rest in
    // bank1. Row-major order makes the bank-local address simply p, or
    // p minus one bank for the bottom half.
    assign accept     = pix_valid & pix_ready;
    assign at_end     = (p_reg == P_LAST);
    assign frame_bad  = accept & (pix_last ^ at_end);
    assign frame_good = accept & pix_last & at_end;
    assign in_bank1   = (p_reg >= P_BANK);
    assign local_addr = in_bank1 ? LA'(p_reg - P_BANK) : p_reg[LA-1:0];

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic. A malformed frame never advances the state, and a
    // scan_done outside PENDING (including the final-pixel cycle in RUN) is
    // deliberately ignored so the swap waits for a complete scan.
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE:    if (enable)     state_next = FILL;
            FILL:    if (frame_good) state_next = FLUSH;
            FLUSH:                   state_next = START;
            START:                   state_next = RUN;
            RUN:     if (frame_good) state_next = PENDING;
            PENDING: if (scan_done)  state_next = RUN;
            default:                 state_next = IDLE;
        endcase
    end

    // Moore-style outputs plus the swap strobe for the frame-select registers.
    always_comb begin
        pix_ready = enable & ((state_reg == FILL) | (state_reg == RUN));
        go        = (state_reg == START);
        swap      = (state_reg == FLUSH) | ((state_reg == PENDING) & scan_done);
    end

    // Datapath: pixel counter, frame selects and the registered RAM write port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p_reg         <= '0;
            rd_frame_reg  <= 1'b0;
            wr_frame_reg  <= 1'b0;
            bank0_wen_reg <= 1'b0;
            bank1_wen_reg <= 1'b0;
            frame_err_reg <= 1'b0;
            w_addr_reg    <= '0;
            w_data_reg    <= '0;
        end else begin
            bank0_wen_reg <= accept & ~in_bank1;
            bank1_wen_reg <= accept & in_bank1;
            frame_err_reg <= frame_bad;
            if (accept) begin
                // The offending pixel of a bad frame is still written; the
                // counter then restarts so the frame is discarded.
                w_addr_reg <= {wr_frame_reg, local_addr};
                w_data_reg <= pix_data;
                p_reg      <= (frame_bad | frame_good) ? '0 : p_reg + 1'b1;
            end
            if (swap) begin
                rd_frame_reg <= wr_frame_reg;
                wr_frame_reg <= ~wr_frame_reg;
            end
        end
    end

    assign bank0_wen  = bank0_wen_reg;
    assign bank1_wen  = bank1_wen_reg;
    assign w_addr     = w_addr_reg;
    assign w_data     = w_data_reg;
    assign frame_err  = frame_err_reg;
    assign bank_raddr = {rd_frame_reg, r_addr};

endmodule

// File: tb/tb_frame_swap_ctrl.sv
// Testbench for frame_swap_ctrl on an 8x4 panel (BANK_SIZE=16, AW=5).
module tb_frame_swap_ctrl;

    localparam int W     = 8;
    localparam int H     = 4;
    localparam int TOTAL = W * H;
    localparam int BANK  = TOTAL / 2;
    localparam int LA    = 4;
    localparam int AW    = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          enable = 1'b0;
    logic          pix_valid = 1'b0;
    logic          pix_last = 1'b0;
    logic          scan_done = 1'b0;
    logic [15:0]   pix_data = '0;
    logic [LA-1:0] r_addr = '0;
    logic          pix_ready, bank0_wen, bank1_wen, go, frame_err;
    logic [AW-1:0] w_addr, bank_raddr;
    logic [15:0]   w_data;

    frame_swap_ctrl #(.MATRIX_HEIGHT(H), .MATRIX_WIDTH(W)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .pix_last(pix_last), .bank0_wen(bank0_wen), .bank1_wen(bank1_wen),
        .w_addr(w_addr), .w_data(w_data), .r_addr(r_addr),
        .bank_raddr(bank_raddr), .go(go), .scan_done(scan_done),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: frame-level bookkeeping, not a state machine copy.
    logic        m_started, m_first_done, m_back_full, m_wr, m_rd;
    int          m_go_cnt, m_p;
    logic        e_wen0, e_wen1, e_err;
    logic [AW-1:0] e_addr;
    logic [15:0] e_data;
    logic        ready_seen;

    typedef struct {
        logic        en;
        logic        v;
        logic        last;
        logic [15:0] data;
        logic        exp_ready;
        logic        exp_wen0;
        logic        exp_wen1;
        logic [AW-1:0] exp_addr;
        logic        exp_go;
    } vec_t;

    vec_t tbl[36];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_started = 0; m_first_done = 0; m_back_full = 0;
        m_wr = 0; m_rd = 0; m_go_cnt = 0; m_p = 0;
        e_wen0 = 0; e_wen1 = 0; e_err = 0; e_addr = '0; e_data = '0;
    endtask

    // One clock cycle: drive inputs, check ready before the edge, advance the
    // model across the edge, then check every registered output after it.
    task automatic step(input logic en, input logic v, input logic last,
                        input logic [15:0] data, input logic scan);
        logic exp_rdy, acc, is_end;
        int   row, col, loc;
        enable = en; pix_valid = v; pix_last = last; pix_data = data;
        scan_done = scan; r_addr = LA'($urandom);
        #1;
        ready_seen = pix_ready;
        exp_rdy = en && m_started && (m_go_cnt == 0) && !m_back_full;
        chk("pix_ready", pix_ready, exp_rdy);
        acc = v && exp_rdy;

        e_wen0 = 0; e_wen1 = 0; e_err = 0;
        // First frame: swap one cycle after its last write, go one cycle later.
        if (m_go_cnt == 2) begin
            m_go_cnt = 1; m_rd = m_wr; m_wr = !m_wr;
        end else if (m_go_cnt == 1) begin
            m_go_cnt = 0;
        end
        // Completed back frame waits for a scan boundary.
        if (scan && m_back_full) begin
            m_back_full = 0; m_rd = m_wr; m_wr = !m_wr;
        end
        if (acc) begin
            row = m_p / W; col = m_p % W;
            if (row < H / 2) begin
                e_wen0 = 1; loc = row * W + col;
            end else begin
                e_wen1 = 1; loc = (row - H / 2) * W + col;
            end
            e_addr = AW'(int'(m_wr) * BANK + loc);
            e_data = data;
            is_end = (m_p == TOTAL - 1);
            if (last != is_end) begin
                e_err = 1; m_p = 0;
            end else if (is_end) begin
                m_p = 0;
                if (!m_first_done) begin
                    m_first_done = 1; m_go_cnt = 2;
                end else begin
                    m_back_full = 1;
                end
            end else begin
                m_p++;
            end
        end
        if (en && !m_started) m_started = 1;

        @(posedge clk); #1;
        chk("bank0_wen", bank0_wen, e_wen0);
        chk("bank1_wen", bank1_wen, e_wen1);
        chk("frame_err", frame_err, e_err);
        chk("go", go, m_go_cnt == 1);
        chk("bank_raddr", bank_raddr, {m_rd, r_addr});
        if (e_wen0 || e_wen1) begin
            chk("w_addr", w_addr, e_addr);
            chk("w_data", w_data, e_data);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_go"}, go, 0);
        chk({tag, "_wen0"}, bank0_wen, 0);
        chk({tag, "_wen1"}, bank1_wen, 0);
        chk({tag, "_waddr"}, w_addr, 0);
        chk({tag, "_wdata"}, w_data, 0);
        chk({tag, "_ready"}, pix_ready, 0);
        chk({tag, "_err"}, frame_err, 0);
        chk({tag, "_raddr"}, bank_raddr, {1'b0, r_addr});
    endtask

    task automatic pixels(input int from, input int to, input int last_at, input logic scan_on_last);
        for (int i = from; i <= to; i++)
            step(1, 1, i == last_at, 16'($urandom), (i == to) ? scan_on_last : 1'b0);
    endtask

    initial begin
        int go_count;
        logic l;
        model_reset();

        // Directed first-frame table: pre-edge ready, post-edge write and go.
        tbl[0] = '{1, 0, 0, 16'h0, 0, 0, 0, '0, 0};
        for (int i = 0; i < TOTAL; i++)
            tbl[i + 1] = '{1, 1, i == TOTAL - 1, 16'(i), 1, i < BANK, i >= BANK,
                           AW'(i < BANK ? i : i - BANK), 0};
        tbl[33] = '{1, 0, 0, 16'h0, 0, 0, 0, '0, 1};
        tbl[34] = '{1, 0, 0, 16'h0, 0, 0, 0, '0, 0};
        tbl[35] = '{1, 0, 0, 16'h0, 1, 0, 0, '0, 0};

        // Power-up reset with enable already high.
        enable = 1; r_addr = 4'h9;
        #1;
        check_reset_outputs("por");
        @(posedge clk); @(posedge clk); #1;
        rst = 1;

        for (int k = 0; k < 36; k++) begin
            step(tbl[k].en, tbl[k].v, tbl[k].last, tbl[k].data, 0);
            chk($sformatf("tbl%0d_ready", k), ready_seen, tbl[k].exp_ready);
            chk($sformatf("tbl%0d_wen0", k), bank0_wen, tbl[k].exp_wen0);
            chk($sformatf("tbl%0d_wen1", k), bank1_wen, tbl[k].exp_wen1);
            chk($sformatf("tbl%0d_go", k), go, tbl[k].exp_go);
            if (tbl[k].exp_wen0 || tbl[k].exp_wen1) begin
                chk($sformatf("tbl%0d_addr", k), w_addr, tbl[k].exp_addr);
                chk($sformatf("tbl%0d_data", k), w_data, tbl[k].data);
            end
        end
        chk("first_rd_msb", bank_raddr[AW-1], 0);

        // Back frame: written to frame 1, held until scan_done.
        step(1, 1, 0, 16'h1234, 0);
        chk("back_p0_addr", w_addr, 16);
        pixels(1, 31, 31, 0);
        for (int k = 0; k < 3; k++) begin
            step(1, 0, 0, 16'h0, 0);
            chk("pending_ready", ready_seen, 0);
        end
        step(1, 0, 0, 16'h0, 1);
        chk("swap_rd_msb", bank_raddr[AW-1], 1);
        chk("swap_ready", pix_ready, 1);
        step(1, 1, 0, 16'hbeef, 0);
        chk("after_swap_addr", w_addr, 0);

        // Framing error: early pix_last at pixel 10.
        pixels(1, 9, 99, 0);
        step(1, 1, 1, 16'h00aa, 0);
        chk("err_pulse", frame_err, 1);
        step(1, 1, 0, 16'h00bb, 0);
        chk("err_once", frame_err, 0);
        chk("err_restart_addr", w_addr, 0);
        step(1, 0, 0, 16'h0, 1);
        chk("err_no_swap", bank_raddr[AW-1], 1);

        // Final pixel coincides with scan_done: swap deferred.
        pixels(1, 31, 31, 1);
        chk("coincide_no_swap", bank_raddr[AW-1], 1);
        step(1, 0, 0, 16'h0, 0);
        chk("coincide_ready", ready_seen, 0);
        step(1, 0, 0, 16'h0, 1);
        chk("deferred_swap", bank_raddr[AW-1], 0);

        // Reset in the middle of a frame, then refill from scratch.
        pixels(0, 20, 99, 0);
        #2; rst = 0; #1;
        check_reset_outputs("midrst");
        model_reset();
        @(posedge clk); #1;
        rst = 1;
        step(1, 0, 0, 16'h0, 0);
        step(1, 1, 0, 16'h5555, 0);
        chk("refill_addr", w_addr, 0);
        pixels(1, 31, 31, 0);
        go_count = 0;
        for (int k = 0; k < 4; k++) begin
            step(1, 0, 0, 16'h0, 0);
            go_count += int'(go);
        end
        chk("refill_go_once", go_count, 1);

        // Randomised traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            if (m_p == TOTAL - 1) l = ($urandom_range(9) != 0);
            else                  l = ($urandom_range(39) == 0);
            step($urandom_range(9) != 0, $urandom_range(9) < 7, l,
                 16'($urandom), $urandom_range(19) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/frame_swap_ctrl.md
# frame_swap_ctrl

Double-buffer controller between the host pixel writer, the two scanline RAM banks (`memory`, top/bottom half) and `led_output`. Each bank is sized for two frames. The host always writes the back frame while `led_output` scans the front frame. The block routes raster-order pixels to the correct bank and address, starts `led_output` with a `go` pulse once the first frame is loaded, and swaps front/back frames only at a scan boundary, so the display never shows a partially written frame.

## Interface
- `MATRIX_HEIGHT`, 32, panel rows; even.
- `MATRIX_WIDTH`, 64, panel columns.
- Derived: BANK_SIZE = MATRIX_HEIGHT*MATRIX_WIDTH/2; LA = $clog2(BANK_SIZE); AW = LA+1 (MSB = frame select).
- `clk` in 1: system clock; single clock domain.
- `rst` in 1: asynchronous, active-low reset (0 = reset).
- `enable` in 1: permits leaving IDLE and accepting pixels.
- `pix_valid` in 1: host pixel valid.
- `pix_ready` out 1: controller accepts the pixel; a transfer occurs when valid&ready at a rising edge.
- `pix_data` in 16: RGB565 pixel.
- `pix_last` in 1: marks the final pixel of a frame.
- `bank0_wen` out 1: write strobe, top-half bank.
- `bank1_wen` out 1: write strobe, bottom-half bank.
- `w_addr` out AW: bank write address.
- `w_data` out 16: bank write data.
- `r_addr` in LA: read address from `led_output`.
- `bank_raddr` out AW: combinational {rd_frame, r_addr}.
- `go` out 1: one-cycle start pulse to `led_output`.
- `scan_done` in 1: one-cycle pulse from `led_output` at the end of a full panel scan.
- `frame_err` out 1: one-cycle pulse when a framing error is detected.

## Operation
- States:
  - IDLE→FILL when enable=1.
  - FILL→FLUSH when the final pixel is accepted.
  - FLUSH→START after one cycle.
  - START→RUN after one cycle; go=1 only in START.
  - RUN→PENDING when the final pixel is accepted.
  - PENDING→RUN on scan_done.
- pix_ready = enable & (state ∈ {FILL, RUN}).
- Pixel counter p runs 0..H*W-1. Derived values: row = p / W, col = p % W.
  - Rows below H/2 write bank0, using local = row*W+col.
  - Remaining rows write bank1, using local = (row-H/2)*W+col.
  - w_addr = {wr_frame, local}.
- Final pixel is p = H*W-1 with pix_last=1.
- Framing error on either condition:
  - pix_last=1 at p ≠ H*W-1, or
  - pix_last=0 at p = H*W-1.
- Framing error response:
  - The offending pixel is still written.
  - frame_err pulses for one cycle.
  - p resets to 0 and the frame is discarded: no state change, no swap.
- Leaving FLUSH: rd_frame ← wr_frame and wr_frame ← ~wr_frame.
- On scan_done in PENDING: rd_frame ← wr_frame and wr_frame ← ~wr_frame, both on the same edge.
- scan_done outside PENDING is ignored.
- scan_done in the same cycle as final-pixel acceptance in RUN is ignored. The swap waits for the next scan_done.
- enable=0 stalls the writer only. Display and pending swaps continue.

## Timing
- Reset values (asynchronous, immediate):
  - state=IDLE, p=0, rd_frame=0, wr_frame=0.
  - All outputs 0, including go, wen, w_addr, w_data, pix_ready and frame_err.
  - bank_raddr = {0, r_addr}.
- Reset mid-frame discards the partial frame. After release, the block behaves as after power-up.
- Write latency: a pixel accepted at edge N gives wen/w_addr/w_data valid for exactly the cycle after edge N. The RAM commits at edge N+1.
- Maximum throughput is one pixel per cycle, with no bubbles inside a frame.
- go is high during the second cycle after the final pixel's acceptance edge, for exactly one cycle. This follows the last RAM write.
- Swap: with scan_done high in the cycle before edge M, bank_raddr MSB and pix_ready change right after edge M.
- frame_err pulses in the same cycle as the erroneous pixel's write strobe.

## Test plan
- W=8, H=4 (BANK_SIZE=16, AW=5); reset held low → every output 0 and pix_ready=0. Release with enable=1 → pix_ready=1 on the next cycle.
- Fill a frame with data=i, i=0..31, pix_last on 31:
  - pixel 5 → bank0_wen, w_addr=5, w_data=5.
  - pixel 16 → bank1_wen, w_addr=0.
  - pixel 31 → bank1_wen, w_addr=15.
  - exactly one go pulse, two cycles after acceptance of pixel 31.
  - bank_raddr MSB=0 afterwards.
- Back frame: pixel 0 → w_addr=16. After pixel 31, pix_ready=0 until scan_done. One cycle later, bank_raddr MSB=1 and pix_ready=1, and the next pixel 0 → w_addr=0.
- pix_last at pixel 10 → frame_err for one cycle; the next pixel writes w_addr local 0; scan_done causes no swap.
- Final pixel accepted in the same cycle as scan_done → no swap; the swap happens on the following scan_done.
- rst low mid-frame at pixel 20 → all outputs 0 immediately. Refill → first write w_addr=0, and go fires again after pixel 31.
